instr_bus_xbar: RTL and testbench

Instruction-side address decoder and response router between the core's fetch port and its instruction slaves: the boot ROM (0x0000_xxxx) and on-chip SRAM (0x0001_xxxx). It forwards each request to exactly one slave, tracks outstanding fetches in order, and returns responses to the core in request order. Unmapped fetches get a synthesized error response, and response-protocol violations are flagged.

---
 rtl/instr_bus_xbar_if.sv | 49 ++++
 rtl/instr_bus_xbar.sv | 143 ++++++++++++++
 tb/tb_instr_bus_xbar.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_bus_xbar_if.sv
// rtl/instr_bus_xbar_if.sv - fetch port, ROM port and RAM port bundle for instr_bus_xbar
interface instr_bus_xbar_if;
  // core fetch port
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic [31:0] instr_addr_i;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic [6:0]  instr_rdata_intg_o;
  logic        instr_err_o;
  // boot ROM port
  logic        rom_req_o;
  logic        rom_gnt_i;
  logic [31:0] rom_addr_o;
  logic        rom_rvalid_i;
  logic [31:0] rom_rdata_i;
  logic [6:0]  rom_rdata_intg_i;
  logic        rom_err_i;
  // SRAM port
  logic        ram_req_o;
  logic        ram_gnt_i;
  logic [31:0] ram_addr_o;
  logic        ram_rvalid_i;
  logic [31:0] ram_rdata_i;
  logic [6:0]  ram_rdata_intg_i;
  logic        ram_err_i;
  // sticky protocol-violation flag
  logic        proto_err_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_rdata_intg_o, instr_err_o,
    output rom_req_o, rom_addr_o,
    input  rom_gnt_i, rom_rvalid_i, rom_rdata_i, rom_rdata_intg_i, rom_err_i,
    output ram_req_o, ram_addr_o,
    input  ram_gnt_i, ram_rvalid_i, ram_rdata_i, ram_rdata_intg_i, ram_err_i,
    output proto_err_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_rdata_intg_o, instr_err_o,
    input  rom_req_o, rom_addr_o,
    output rom_gnt_i, rom_rvalid_i, rom_rdata_i, rom_rdata_intg_i, rom_err_i,
    input  ram_req_o, ram_addr_o,
    output ram_gnt_i, ram_rvalid_i, ram_rdata_i, ram_rdata_intg_i, ram_err_i,
    input  proto_err_o
  );
endinterface

// File: rtl/instr_bus_xbar.sv
// rtl/instr_bus_xbar.sv - instruction fetch decoder with in-order response routing
module instr_bus_xbar #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter logic [31:0] ROM_MASK = 32'hFFFF_0000,
  parameter logic [31:0] RAM_BASE = 32'h0001_0000,
  parameter logic [31:0] RAM_MASK = 32'hFFFF_0000
) (
  input  logic              clk,
  input  logic              rst,
  instr_bus_xbar_if.slave   bus
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    TAG_ROM = 2'd0,
    TAG_RAM = 2'd1,
    TAG_ERR = 2'd2
  } tag_e;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  tag_e          tag_q [MAX_OUTSTANDING];
  logic          proto_err_q;

  logic sel_rom, sel_ram, unmapped;
  logic full, nonempty;
  logic push, pop;
  tag_e push_tag, head_tag;
  logic head_rom, head_ram;
  logic stray;

  assign sel_rom  = (bus.instr_addr_i & ROM_MASK) == ROM_BASE;
  assign sel_ram  = ((bus.instr_addr_i & RAM_MASK) == RAM_BASE) && !sel_rom;
  assign unmapped = !sel_rom && !sel_ram;

  assign full     = (count_q == MAX_CNT);
  assign nonempty = (count_q != '0);
  assign head_tag = tag_q[rd_ptr_q];
  assign head_rom = nonempty && (head_tag == TAG_ROM);
  assign head_ram = nonempty && (head_tag == TAG_RAM);

  // Both slaves see the raw fetch address; only the decoded one gets req.
  assign bus.rom_addr_o = bus.instr_addr_i;
  assign bus.ram_addr_o = bus.instr_addr_i;

  // Request routing and grant return; everything is blocked in reset or when full.
  always_comb begin
    bus.rom_req_o   = 1'b0;
    bus.ram_req_o   = 1'b0;
    bus.instr_gnt_o = 1'b0;
    push_tag        = TAG_ERR;
    if (rst && bus.instr_req_i && !full) begin
      if (sel_rom) begin
        bus.rom_req_o   = 1'b1;
        bus.instr_gnt_o = bus.rom_gnt_i;
        push_tag        = TAG_ROM;
      end else if (sel_ram) begin
        bus.ram_req_o   = 1'b1;
        bus.instr_gnt_o = bus.ram_gnt_i;
        push_tag        = TAG_RAM;
      end else if (unmapped) begin
        bus.instr_gnt_o = 1'b1;
        push_tag        = TAG_ERR;
      end
    end
  end

  assign push = bus.instr_gnt_o;

  // Response steering by the oldest outstanding tag; data is zero unless valid.
  always_comb begin
    bus.instr_rvalid_o     = 1'b0;
    bus.instr_rdata_o      = '0;
    bus.instr_rdata_intg_o = '0;
    bus.instr_err_o        = 1'b0;
    if (rst && nonempty) begin
      case (head_tag)
        TAG_ROM: begin
          if (bus.rom_rvalid_i) begin
            bus.instr_rvalid_o     = 1'b1;
            bus.instr_rdata_o      = bus.rom_rdata_i;
            bus.instr_rdata_intg_o = bus.rom_rdata_intg_i;
            bus.instr_err_o        = bus.rom_err_i;
          end
        end
        TAG_RAM: begin
          if (bus.ram_rvalid_i) begin
            bus.instr_rvalid_o     = 1'b1;
            bus.instr_rdata_o      = bus.ram_rdata_i;
            bus.instr_rdata_intg_o = bus.ram_rdata_intg_i;
            bus.instr_err_o        = bus.ram_err_i;
          end
        end
        TAG_ERR: begin
          bus.instr_rvalid_o = 1'b1;
          bus.instr_err_o    = 1'b1;
        end
        default: begin
          bus.instr_rvalid_o = 1'b0;
        end
      endcase
    end
  end

  assign pop = bus.instr_rvalid_o;

  // A slave response is stray unless that slave owns the head entry.
  assign stray = (bus.rom_rvalid_i && !head_rom) || (bus.ram_rvalid_i && !head_ram);

  // Tracking FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Tag storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= push_tag;
  end

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      proto_err_q <= 1'b0;
    end else if (stray) begin
      proto_err_q <= 1'b1;
    end
  end

  assign bus.proto_err_o = proto_err_q;

endmodule

// File: tb/tb_instr_bus_xbar.sv
// tb/tb_instr_bus_xbar.sv - vector table, corner sequences and model-checked random fetches
module tb_instr_bus_xbar;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_bus_xbar_if bus ();

  instr_bus_xbar dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] ROM_INTG = 7'h15;
  localparam logic [6:0] RAM_INTG = 7'h2A;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        rg;
    logic        mg;
    logic        rv;
    logic [31:0] rd;
    logic        mv;
    logic [31:0] md;
    logic        e_gnt;
    logic        e_rreq;
    logic        e_mreq;
    logic        e_rv;
    logic [31:0] e_rd;
    logic [6:0]  e_intg;
    logic        e_err;
    logic        e_proto;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic rg, input logic mg,
                              input logic rv, input logic [31:0] rd, input logic mv, input logic [31:0] md,
                              input logic e_gnt, input logic e_rreq, input logic e_mreq, input logic e_rv,
                              input logic [31:0] e_rd, input logic [6:0] e_intg, input logic e_err,
                              input logic e_proto);
    vec_t v;
    v.req = req; v.addr = addr; v.rg = rg; v.mg = mg;
    v.rv = rv; v.rd = rd; v.mv = mv; v.md = md;
    v.e_gnt = e_gnt; v.e_rreq = e_rreq; v.e_mreq = e_mreq; v.e_rv = e_rv;
    v.e_rd = e_rd; v.e_intg = e_intg; v.e_err = e_err; v.e_proto = e_proto;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic set_in(input logic req, input logic [31:0] addr, input logic rg, input logic mg,
                        input logic rv, input logic [31:0] rd, input logic mv, input logic [31:0] md);
    bus.instr_req_i      = req;
    bus.instr_addr_i     = addr;
    bus.rom_gnt_i        = rg;
    bus.ram_gnt_i        = mg;
    bus.rom_rvalid_i     = rv;
    bus.rom_rdata_i      = rd;
    bus.rom_rdata_intg_i = ROM_INTG;
    bus.rom_err_i        = 1'b0;
    bus.ram_rvalid_i     = mv;
    bus.ram_rdata_i      = md;
    bus.ram_rdata_intg_i = RAM_INTG;
    bus.ram_err_i        = 1'b0;
  endtask

  task automatic check_outs(input string name, input int idx, input logic e_gnt, input logic e_rreq,
                            input logic e_mreq, input logic e_rv, input logic [31:0] e_rd,
                            input logic [6:0] e_intg, input logic e_err, input logic e_proto);
    chk({name, ".gnt"},   idx, 32'(bus.instr_gnt_o),        32'(e_gnt));
    chk({name, ".rreq"},  idx, 32'(bus.rom_req_o),          32'(e_rreq));
    chk({name, ".mreq"},  idx, 32'(bus.ram_req_o),          32'(e_mreq));
    chk({name, ".rv"},    idx, 32'(bus.instr_rvalid_o),     32'(e_rv));
    chk({name, ".rdata"}, idx, bus.instr_rdata_o,           e_rd);
    chk({name, ".intg"},  idx, 32'(bus.instr_rdata_intg_o), 32'(e_intg));
    chk({name, ".err"},   idx, 32'(bus.instr_err_o),        32'(e_err));
    chk({name, ".proto"}, idx, 32'(bus.proto_err_o),        32'(e_proto));
  endtask

  // Reference model state: outstanding targets in request order (0=ROM, 1=RAM, 2=unmapped).
  int q[$];
  bit m_proto;

  initial begin
    //            req addr          rg mg rv rd            mv md            gnt rrq mrq rv  rdata         intg      err proto
    vt[0]  = mk(1, 32'h0000_0080, 1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h0,        7'h0,     0, 0);
    vt[1]  = mk(0, 32'h0,         0, 0, 1, 32'h0001_8137, 0, 32'h0,       0, 0, 0, 1, 32'h0001_8137, ROM_INTG, 0, 0);
    vt[2]  = mk(1, 32'h0000_0080, 1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h0,        7'h0,     0, 0);
    vt[3]  = mk(1, 32'h0000_0084, 1, 0, 1, 32'hA1A1_0001, 0, 32'h0,       1, 1, 0, 1, 32'hA1A1_0001, ROM_INTG, 0, 0);
    vt[4]  = mk(0, 32'h0,         0, 0, 1, 32'hA2A2_0002, 0, 32'h0,       0, 0, 0, 1, 32'hA2A2_0002, ROM_INTG, 0, 0);
    vt[5]  = mk(1, 32'h0003_0000, 1, 1, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,        7'h0,     0, 0);
    vt[6]  = mk(0, 32'h0,         0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'h0,        7'h0,     1, 0);
    vt[7]  = mk(1, 32'h0001_0000, 0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h0,        7'h0,     0, 0);
    vt[8]  = mk(1, 32'h0001_0004, 0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h0,        7'h0,     0, 0);
    vt[9]  = mk(1, 32'h0001_0008, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,        7'h0,     0, 0);
    vt[10] = mk(1, 32'h0001_0008, 0, 1, 0, 32'h0,        1, 32'hB1B1_0001, 0, 0, 0, 1, 32'hB1B1_0001, RAM_INTG, 0, 0);
    vt[11] = mk(1, 32'h0001_0008, 0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h0,        7'h0,     0, 0);
    vt[12] = mk(0, 32'h0,         0, 0, 0, 32'h0,        1, 32'hB2B2_0002, 0, 0, 0, 1, 32'hB2B2_0002, RAM_INTG, 0, 0);
    vt[13] = mk(0, 32'h0,         0, 0, 0, 32'h0,        1, 32'hB3B3_0003, 0, 0, 0, 1, 32'hB3B3_0003, RAM_INTG, 0, 0);
    vt[14] = mk(1, 32'h0000_0100, 1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h0,        7'h0,     0, 0);
    vt[15] = mk(1, 32'h0003_0000, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h0,        7'h0,     0, 0);
    vt[16] = mk(0, 32'h0,         0, 0, 1, 32'hC1C1_0001, 0, 32'h0,       0, 0, 0, 1, 32'hC1C1_0001, ROM_INTG, 0, 0);
    vt[17] = mk(0, 32'h0,         0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'h0,        7'h0,     1, 0);
    vt[18] = mk(0, 32'h0,         0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,       0, 0, 0, 0, 32'h0,        7'h0,     0, 0);
    vt[19] = mk(0, 32'h0,         0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,        7'h0,     0, 1);
    vt[20] = mk(1, 32'h0000_0080, 1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h0,        7'h0,     0, 1);

    // Reset state: everything forced quiet even with active inputs.
    rst = 1'b0;
    set_in(1, 32'h0000_0080, 1, 0, 1, 32'h1234_5678, 0, 32'h0);
    repeat (2) @(posedge clk);
    #4;
    check_outs("reset", 0, 0, 0, 0, 0, 32'h0, 7'h0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed cycle table from an empty FIFO.
    for (int i = 0; i < 21; i++) begin
      set_in(vt[i].req, vt[i].addr, vt[i].rg, vt[i].mg, vt[i].rv, vt[i].rd, vt[i].mv, vt[i].md);
      #3;
      check_outs("vec", i, vt[i].e_gnt, vt[i].e_rreq, vt[i].e_mreq, vt[i].e_rv, vt[i].e_rd,
                 vt[i].e_intg, vt[i].e_err, vt[i].e_proto);
      @(posedge clk); #1;
    end

    // Reset with one ROM fetch outstanding and proto_err set.
    rst = 1'b0;
    set_in(1, 32'h0000_0080, 1, 0, 1, 32'h5555_5555, 0, 32'h0);
    #3;
    check_outs("rst_mid", 0, 0, 0, 0, 0, 32'h0, 7'h0, 0, 1);
    @(posedge clk); #1;
    #3;
    check_outs("rst_mid", 1, 0, 0, 0, 0, 32'h0, 7'h0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    // Late ROM response for the discarded fetch.
    set_in(0, 32'h0, 0, 0, 1, 32'h6666_6666, 0, 32'h0);
    #3;
    check_outs("late", 0, 0, 0, 0, 0, 32'h0, 7'h0, 0, 0);
    @(posedge clk); #1;
    set_in(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    #3;
    check_outs("late", 1, 0, 0, 0, 0, 32'h0, 7'h0, 0, 1);
    @(posedge clk); #1;

    // Clean start for the random phase.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    m_proto = 1'b0;

    for (int n = 0; n < 400; n++) begin
      logic        req, rg, mg, rv, mv, re, me, sr, sm, full;
      logic [31:0] addr, rd, md;
      logic [6:0]  ri, mi;
      logic        e_gnt, e_rreq, e_mreq, e_rv, e_err, stray;
      logic [31:0] e_rd;
      logic [6:0]  e_intg;
      int          head, tag;

      req = 1'($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0: addr = {16'h0000, 16'($urandom)};
        1: addr = {16'h0001, 16'($urandom)};
        default: addr = {16'($urandom_range(2, 16'hFFFF)), 16'($urandom)};
      endcase
      rg = 1'($urandom_range(0, 1));
      mg = 1'($urandom_range(0, 1));
      rd = $urandom; md = $urandom;
      ri = 7'($urandom); mi = 7'($urandom);
      re = 1'($urandom_range(0, 1)); me = 1'($urandom_range(0, 1));
      head = (q.size() > 0) ? q[0] : -1;
      rv = (head == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      mv = (head == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (n == 300) begin
        rv = 1'b1;
        mv = 1'b1;
      end

      bus.instr_req_i = req; bus.instr_addr_i = addr;
      bus.rom_gnt_i = rg; bus.ram_gnt_i = mg;
      bus.rom_rvalid_i = rv; bus.rom_rdata_i = rd; bus.rom_rdata_intg_i = ri; bus.rom_err_i = re;
      bus.ram_rvalid_i = mv; bus.ram_rdata_i = md; bus.ram_rdata_intg_i = mi; bus.ram_err_i = me;

      // Expected behaviour from the decode map and the outstanding queue.
      sr   = (addr & 32'hFFFF_0000) == 32'h0000_0000;
      sm   = ((addr & 32'hFFFF_0000) == 32'h0001_0000) && !sr;
      full = (q.size() == 2);
      e_rreq = req && sr && !full;
      e_mreq = req && sm && !full;
      e_gnt  = req && !full && (sr ? rg : (sm ? mg : 1'b1));
      tag    = sr ? 0 : (sm ? 1 : 2);
      e_rv = 1'b0; e_rd = 32'h0; e_intg = 7'h0; e_err = 1'b0;
      if (head == 0 && rv) begin e_rv = 1'b1; e_rd = rd; e_intg = ri; e_err = re; end
      if (head == 1 && mv) begin e_rv = 1'b1; e_rd = md; e_intg = mi; e_err = me; end
      if (head == 2)       begin e_rv = 1'b1; e_err = 1'b1; end
      stray = (rv && head != 0) || (mv && head != 1);

      #3;
      check_outs("rand", n, e_gnt, e_rreq, e_mreq, e_rv, e_rd, e_intg, e_err, m_proto);
      chk("rand.rom_addr", n, bus.rom_addr_o, addr);
      chk("rand.ram_addr", n, bus.ram_addr_o, addr);

      @(posedge clk); #1;
      if (e_rv) void'(q.pop_front());
      if (e_gnt) q.push_back(tag);
      if (stray) m_proto = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
